mux_n_1_seq: RTL and testbench



---
 rtl/mux_n_1_seq_if.sv | 26 ++
 rtl/mux_n_1_seq.sv | 126 ++++++++++++
 tb/tb_mux_n_1_seq.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/mux_n_1_seq_if.sv
// Channel data, select handshake and registered result of the N:1 selector.
interface mux_n_1_seq_if #(
    parameter int N_CH  = 8,
    parameter int DW    = 1,
    parameter int SEL_W = 3
);
    logic [N_CH*DW-1:0] d_in;
    logic [SEL_W-1:0]   sel;
    logic               sel_valid;
    logic               mode;
    logic [DW-1:0]      out;
    logic               out_valid;
    logic [SEL_W-1:0]   out_ch;
    logic               sel_err;
    logic               scan_wrap;

    modport master (
        output d_in, sel, sel_valid, mode,
        input  out, out_valid, out_ch, sel_err, scan_wrap
    );

    modport slave (
        input  d_in, sel, sel_valid, mode,
        output out, out_valid, out_ch, sel_err, scan_wrap
    );
endinterface

// File: rtl/mux_n_1_seq.sv
// Registered N:1 selector with a latched, validated select (direct mode)
// and an autonomous channel scan that holds each channel SCAN_HOLD cycles.
module mux_n_1_seq #(
    parameter int N_CH      = 8,
    parameter int DW        = 1,
    parameter int SEL_W     = 3,
    parameter int SCAN_HOLD = 1
) (
    input  logic          clk,
    input  logic          global_resetn,
    mux_n_1_seq_if.slave  bus
);

    localparam int HW = $clog2(SCAN_HOLD) + 1;
    localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(N_CH - 1);
    localparam logic [HW-1:0]    HOLD_TC = HW'(SCAN_HOLD - 1);

    if (SEL_W != $clog2(N_CH)) begin : g_sel_w_chk
        $error("mux_n_1_seq: SEL_W must equal clog2(N_CH)");
    end
    if (N_CH < 2 || N_CH > 64) begin : g_n_ch_chk
        $error("mux_n_1_seq: N_CH must be in 2..64");
    end
    if (SCAN_HOLD < 1 || SCAN_HOLD > 256) begin : g_hold_chk
        $error("mux_n_1_seq: SCAN_HOLD must be in 1..256");
    end

    typedef enum logic [1:0] {
        IDLE,
        DIRECT,
        SCAN
    } state_t;

    state_t            state;
    logic [HW-1:0]     hold_cnt;
    logic              sel_legal;
    logic [SEL_W-1:0]  next_ch;

    function automatic logic [DW-1:0] pick(input logic [N_CH*DW-1:0] d,
                                           input logic [SEL_W-1:0]   ch);
        return d[int'(ch)*DW +: DW];
    endfunction

    // Select legality and the modulo-N_CH successor of the current channel.
    always_comb begin
        sel_legal = (int'(bus.sel) < N_CH);
        next_ch   = (bus.out_ch == LAST_CH) ? '0 : bus.out_ch + SEL_W'(1);
    end

    // Mode FSM; out and out_ch are always written together so they never skew.
    always_ff @(posedge clk or negedge global_resetn) begin
        if (!global_resetn) begin
            state         <= IDLE;
            hold_cnt      <= '0;
            bus.out       <= '0;
            bus.out_valid <= 1'b0;
            bus.out_ch    <= '0;
            bus.sel_err   <= 1'b0;
            bus.scan_wrap <= 1'b0;
        end else begin
            bus.sel_err   <= 1'b0;
            bus.scan_wrap <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.mode) begin
                        state         <= SCAN;
                        hold_cnt      <= '0;
                        bus.out_ch    <= '0;
                        bus.out       <= pick(bus.d_in, '0);
                        bus.out_valid <= 1'b1;
                    end else if (bus.sel_valid) begin
                        if (sel_legal) begin
                            state         <= DIRECT;
                            bus.out_ch    <= bus.sel;
                            bus.out       <= pick(bus.d_in, bus.sel);
                            bus.out_valid <= 1'b1;
                        end else begin
                            bus.sel_err <= 1'b1;
                        end
                    end
                end
                DIRECT: begin
                    if (bus.mode) begin
                        state         <= SCAN;
                        hold_cnt      <= '0;
                        bus.out_ch    <= '0;
                        bus.out       <= pick(bus.d_in, '0);
                        bus.out_valid <= 1'b1;
                    end else if (bus.sel_valid && sel_legal) begin
                        bus.out_ch    <= bus.sel;
                        bus.out       <= pick(bus.d_in, bus.sel);
                        bus.out_valid <= 1'b1;
                    end else begin
                        bus.sel_err <= bus.sel_valid;
                        bus.out     <= pick(bus.d_in, bus.out_ch);
                    end
                end
                SCAN: begin
                    if (!bus.mode) begin
                        // Leaving scan keeps the current channel unless a legal
                        // select arrives on the very same edge.
                        state    <= DIRECT;
                        hold_cnt <= '0;
                        if (bus.sel_valid && sel_legal) begin
                            bus.out_ch <= bus.sel;
                            bus.out    <= pick(bus.d_in, bus.sel);
                        end else begin
                            bus.sel_err <= bus.sel_valid;
                            bus.out     <= pick(bus.d_in, bus.out_ch);
                        end
                    end else if (hold_cnt == HOLD_TC) begin
                        hold_cnt      <= '0;
                        bus.out_ch    <= next_ch;
                        bus.out       <= pick(bus.d_in, next_ch);
                        bus.scan_wrap <= (bus.out_ch == LAST_CH);
                    end else begin
                        hold_cnt <= hold_cnt + HW'(1);
                        bus.out  <= pick(bus.d_in, bus.out_ch);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mux_n_1_seq.sv
// Directed bench for mux_n_1_seq: an 8-channel/hold-2 instance for sweep,
// reset, scan, mode switch and tracking; a 5-channel/4-bit instance for
// out-of-range selects.
module tb_mux_n_1_seq;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    mux_n_1_seq_if #(.N_CH(8), .DW(1), .SEL_W(3)) bus_a ();
    mux_n_1_seq_if #(.N_CH(5), .DW(4), .SEL_W(3)) bus_b ();

    mux_n_1_seq #(.N_CH(8), .DW(1), .SEL_W(3), .SCAN_HOLD(2)) dut_a (
        .clk           (clk),
        .global_resetn (rst_n),
        .bus           (bus_a)
    );

    mux_n_1_seq #(.N_CH(5), .DW(4), .SEL_W(3), .SCAN_HOLD(1)) dut_b (
        .clk           (clk),
        .global_resetn (rst_n),
        .bus           (bus_b)
    );

    typedef struct {
        logic [2:0] sel;
        logic       sel_valid;
        logic [7:0] d;
        logic       exp_out;
        logic [2:0] exp_ch;
    } vec_a_t;

    typedef struct {
        logic [2:0]  sel;
        logic        sel_valid;
        logic [19:0] d;
        logic [3:0]  exp_out;
        logic [2:0]  exp_ch;
        logic        exp_valid;
        logic        exp_err;
    } vec_b_t;

    vec_a_t     va [12];
    vec_b_t     vb [7];
    logic [7:0] dval;
    logic       cur4;
    logic       nxt4;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n           = 1'b0;
        bus_a.mode      = 1'b0;
        bus_a.sel_valid = 1'b0;
        bus_a.sel       = '0;
        bus_b.mode      = 1'b0;
        bus_b.sel_valid = 1'b0;
        bus_b.sel       = '0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // Sweep: d=0x55 -> even channels read 1.
        for (int i = 0; i < 8; i++) begin
            va[i].sel       = 3'(i);
            va[i].sel_valid = 1'b1;
            va[i].d         = 8'h55;
            va[i].exp_out   = (i % 2 == 0);
            va[i].exp_ch    = 3'(i);
        end
        va[8]  = '{sel: 3'd3, sel_valid: 1'b0, d: 8'h55, exp_out: 1'b0, exp_ch: 3'd7};
        va[9]  = '{sel: 3'd3, sel_valid: 1'b0, d: 8'hAA, exp_out: 1'b1, exp_ch: 3'd7};
        va[10] = '{sel: 3'd0, sel_valid: 1'b1, d: 8'hAA, exp_out: 1'b0, exp_ch: 3'd0};
        va[11] = '{sel: 3'd5, sel_valid: 1'b1, d: 8'h20, exp_out: 1'b1, exp_ch: 3'd5};

        // Channels ch4..ch0 = E,7,A,3,1.
        vb[0] = '{sel: 3'd6, sel_valid: 1'b1, d: 20'hE7A31, exp_out: 4'h0, exp_ch: 3'd0, exp_valid: 1'b0, exp_err: 1'b1};
        vb[1] = '{sel: 3'd6, sel_valid: 1'b0, d: 20'hE7A31, exp_out: 4'h0, exp_ch: 3'd0, exp_valid: 1'b0, exp_err: 1'b0};
        vb[2] = '{sel: 3'd2, sel_valid: 1'b1, d: 20'hE7A31, exp_out: 4'hA, exp_ch: 3'd2, exp_valid: 1'b1, exp_err: 1'b0};
        vb[3] = '{sel: 3'd7, sel_valid: 1'b1, d: 20'hE7A31, exp_out: 4'hA, exp_ch: 3'd2, exp_valid: 1'b1, exp_err: 1'b1};
        vb[4] = '{sel: 3'd5, sel_valid: 1'b1, d: 20'hE7631, exp_out: 4'h6, exp_ch: 3'd2, exp_valid: 1'b1, exp_err: 1'b1};
        vb[5] = '{sel: 3'd5, sel_valid: 1'b0, d: 20'hE7931, exp_out: 4'h9, exp_ch: 3'd2, exp_valid: 1'b1, exp_err: 1'b0};
        vb[6] = '{sel: 3'd4, sel_valid: 1'b1, d: 20'hE7931, exp_out: 4'hE, exp_ch: 3'd4, exp_valid: 1'b1, exp_err: 1'b0};

        bus_a.d_in = '0; bus_a.sel = '0; bus_a.sel_valid = 1'b0; bus_a.mode = 1'b0;
        bus_b.d_in = '0; bus_b.sel = '0; bus_b.sel_valid = 1'b0; bus_b.mode = 1'b0;

        // Reset state, then idle with no select for 10 cycles.
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_out",       32'(bus_a.out),       32'd0);
        check("rst_out_valid", 32'(bus_a.out_valid), 32'd0);
        check("rst_out_ch",    32'(bus_a.out_ch),    32'd0);
        bus_a.d_in = 8'hFF;
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("idle_out",       32'(bus_a.out),       32'd0);
            check("idle_out_valid", 32'(bus_a.out_valid), 32'd0);
        end

        // Select sweep table.
        for (int i = 0; i < 12; i++) begin
            bus_a.d_in      = va[i].d;
            bus_a.sel       = va[i].sel;
            bus_a.sel_valid = va[i].sel_valid;
            @(negedge clk);
            bus_a.sel_valid = 1'b0;
            if (i == 0) check("first_accept_valid", 32'(bus_a.out_valid), 32'd1);
            repeat (4) @(negedge clk);
            check("sweep_out",    32'(bus_a.out),       32'(va[i].exp_out));
            check("sweep_out_ch", 32'(bus_a.out_ch),    32'(va[i].exp_ch));
            check("sweep_valid",  32'(bus_a.out_valid), 32'd1);
        end

        // Scan with SCAN_HOLD=2: channel k/2, wrap pulse every 16 cycles.
        do_reset();
        dval       = 8'b1011_0010;
        bus_a.d_in = dval;
        bus_a.mode = 1'b1;
        for (int k = 0; k <= 32; k++) begin
            int exp_ch;
            exp_ch = (k / 2) % 8;
            @(negedge clk);
            check("scan_ch",    32'(bus_a.out_ch),    32'(exp_ch));
            check("scan_out",   32'(bus_a.out),       32'(dval[exp_ch]));
            check("scan_valid", 32'(bus_a.out_valid), 32'd1);
            check("scan_wrap",  32'(bus_a.scan_wrap), (k > 0 && k % 16 == 0) ? 32'd1 : 32'd0);
        end

        // Leave scan at ch3 with a legal select on the same edge.
        do_reset();
        bus_a.d_in = 8'b0100_0000;
        bus_a.mode = 1'b1;
        repeat (7) @(negedge clk);
        check("switch_pre_ch", 32'(bus_a.out_ch), 32'd3);
        bus_a.mode      = 1'b0;
        bus_a.sel       = 3'd6;
        bus_a.sel_valid = 1'b1;
        @(negedge clk);
        bus_a.sel_valid = 1'b0;
        check("switch_sel_ch",  32'(bus_a.out_ch), 32'd6);
        check("switch_sel_out", 32'(bus_a.out),    32'd1);

        // Leave scan at ch3 without a select: ch3 is held.
        do_reset();
        bus_a.d_in = 8'b0000_1000;
        bus_a.mode = 1'b1;
        repeat (7) @(negedge clk);
        bus_a.mode = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("switch_hold_ch",  32'(bus_a.out_ch), 32'd3);
            check("switch_hold_out", 32'(bus_a.out),    32'd1);
        end

        // Asynchronous reset mid-scan at ch5.
        do_reset();
        bus_a.d_in = 8'b0010_0000;
        bus_a.mode = 1'b1;
        repeat (11) @(negedge clk);
        check("midscan_pre_ch",  32'(bus_a.out_ch), 32'd5);
        check("midscan_pre_out", 32'(bus_a.out),    32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_out",   32'(bus_a.out),       32'd0);
        check("async_rst_valid", 32'(bus_a.out_valid), 32'd0);
        check("async_rst_ch",    32'(bus_a.out_ch),    32'd0);
        check("async_rst_wrap",  32'(bus_a.scan_wrap), 32'd0);
        @(negedge clk);
        bus_a.mode = 1'b0;
        rst_n      = 1'b1;
        @(negedge clk);
        check("release_wrap",  32'(bus_a.scan_wrap), 32'd0);
        check("release_err",   32'(bus_a.sel_err),   32'd0);
        check("release_valid", 32'(bus_a.out_valid), 32'd0);

        // Data tracking on ch4: changes land just after the edge, so out
        // must still show the pre-edge value at the next sample point.
        do_reset();
        cur4            = 1'b0;
        bus_a.d_in      = 8'h00;
        bus_a.sel       = 3'd4;
        bus_a.sel_valid = 1'b1;
        @(negedge clk);
        bus_a.sel_valid = 1'b0;
        for (int i = 0; i < 16; i++) begin
            @(posedge clk);
            #1;
            nxt4       = ~cur4;
            dval       = 8'($urandom);
            dval[4]    = nxt4;
            bus_a.d_in = dval;
            @(negedge clk);
            check("track_out", 32'(bus_a.out), 32'(cur4));
            cur4 = nxt4;
        end

        // Out-of-range selects on the 5-channel instance.
        do_reset();
        bus_b.mode = 1'b0;
        for (int i = 0; i < 7; i++) begin
            bus_b.d_in      = vb[i].d;
            bus_b.sel       = vb[i].sel;
            bus_b.sel_valid = vb[i].sel_valid;
            @(negedge clk);
            check("b_out",       32'(bus_b.out),       32'(vb[i].exp_out));
            check("b_out_ch",    32'(bus_b.out_ch),    32'(vb[i].exp_ch));
            check("b_out_valid", 32'(bus_b.out_valid), 32'(vb[i].exp_valid));
            check("b_sel_err",   32'(bus_b.sel_err),   32'(vb[i].exp_err));
        end
        bus_b.sel_valid = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
